// File: rtl/fft_ctrl_pkg.sv
// Shared contract for the R16 FFT sequencer: state codes and bus widths that
// every stage-delay tap and address generator decodes.
package fft_ctrl_pkg;

  localparam int S_WIDTH_DEF  = 4;
  localparam int SC_WIDTH_DEF = 3;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LOAD    = 4'd1;
  localparam logic [3:0] ST_COMPUTE = 4'd5;
  localparam logic [3:0] ST_DRAIN   = 4'd6;
  localparam logic [3:0] ST_NEXT    = 4'd7;
  localparam logic [3:0] ST_UNLOAD  = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;

  typedef enum logic [3:0] {
    FSM_IDLE    = ST_IDLE,
    FSM_LOAD    = ST_LOAD,
    FSM_COMPUTE = ST_COMPUTE,
    FSM_DRAIN   = ST_DRAIN,
    FSM_NEXT    = ST_NEXT,
    FSM_UNLOAD  = ST_UNLOAD,
    FSM_DONE    = ST_DONE
  } fsm_e;

  // Taps count only while the datapath is busy on a stage (codes 5/6).
  function automatic logic stage_active(input logic [3:0] st);
    return (st == ST_COMPUTE) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Phase counter: enable, synchronous clear (wins over enable) and a
// terminal-count flag against a runtime limit.
module phase_cnt #(
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for the R16 FFT datapath: LOAD, then COMPUTE/DRAIN per stage with a
// one-cycle NEXT gap between stages, then UNLOAD and a one-cycle DONE.
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int S_WIDTH      = S_WIDTH_DEF,
  parameter int SC_WIDTH     = SC_WIDTH_DEF,
  parameter int NUM_STAGES   = 4,
  parameter int LOAD_CYCLES  = 1024,
  parameter int STAGE_CYCLES = 1024,
  parameter int DRAIN_CYCLES = 56,
  parameter int CNT_WIDTH    = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 out_ready,
  output logic [S_WIDTH-1:0]   state,
  output logic [SC_WIDTH-1:0]  stage,
  output logic [CNT_WIDTH-1:0] cyc_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] LOAD_LIM  = CNT_WIDTH'(LOAD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGE_LIM = CNT_WIDTH'(STAGE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LIM = CNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [SC_WIDTH-1:0]  LAST_STG  = SC_WIDTH'(NUM_STAGES - 1);

  fsm_e                 state_q;
  logic [SC_WIDTH-1:0]  stage_q;
  logic                 cnt_en, cnt_clr, cnt_tc;
  logic [CNT_WIDTH-1:0] cnt_lim;

  // The counter wraps to 0 on the same edge the FSM leaves a timed phase.
  // UNLOAD deliberately keeps counting on its last beat; DONE clears it.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    cnt_lim = LOAD_LIM;
    case (state_q)
      FSM_IDLE:    cnt_clr = start;
      FSM_LOAD: begin
        cnt_en  = in_valid & ~cnt_tc;
        cnt_clr = in_valid & cnt_tc;
      end
      FSM_COMPUTE: begin
        cnt_lim = STAGE_LIM;
        cnt_en  = ~cnt_tc;
        cnt_clr = cnt_tc;
      end
      FSM_DRAIN: begin
        cnt_lim = DRAIN_LIM;
        cnt_en  = ~cnt_tc;
        cnt_clr = cnt_tc;
      end
      FSM_NEXT: begin
        cnt_en = 1'b0;
      end
      FSM_UNLOAD:  cnt_en  = out_ready;
      FSM_DONE:    cnt_clr = 1'b1;
      default:     cnt_clr = 1'b1;
    endcase
  end

  phase_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (cnt_en),
    .clr_i   (cnt_clr),
    .limit_i (cnt_lim),
    .cnt_o   (cyc_cnt),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FSM_IDLE;
      stage_q <= '0;
    end else begin
      case (state_q)
        FSM_IDLE: if (start) begin
          state_q <= FSM_LOAD;
          stage_q <= '0;
        end
        FSM_LOAD:    if (in_valid && cnt_tc) state_q <= FSM_COMPUTE;
        FSM_COMPUTE: if (cnt_tc) state_q <= FSM_DRAIN;
        FSM_DRAIN:   if (cnt_tc) state_q <= (stage_q == LAST_STG) ? FSM_UNLOAD : FSM_NEXT;
        // Stage advances only here, so it is stable across each COMPUTE+DRAIN span.
        FSM_NEXT: begin
          state_q <= FSM_COMPUTE;
          stage_q <= stage_q + SC_WIDTH'(1);
        end
        FSM_UNLOAD:  if (out_ready && cnt_tc) state_q <= FSM_DONE;
        FSM_DONE:    state_q <= FSM_IDLE;
        default:     state_q <= FSM_IDLE;
      endcase
    end
  end

  assign state = S_WIDTH'(state_q);
  assign stage = stage_q;
  assign busy  = (state_q != FSM_IDLE);
  assign done  = (state_q == FSM_DONE);

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: fixed trace table, directed corner sequences,
// random traffic against a phase-list reference model, and a stage-delay tap.
module tb_fft_stage_ctrl;

  localparam int NS = 4, LC = 8, SC = 16, DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]  state;
  logic [2:0]  stage;
  logic [10:0] cyc_cnt;
  logic        busy, done;

  logic        rst6 = 1'b1, start6 = 1'b0, iv6 = 1'b0, or6 = 1'b0;
  logic [3:0]  state6;
  logic [2:0]  stage6;
  logic [10:0] cnt6;
  logic        busy6, done6;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.NUM_STAGES(NS), .LOAD_CYCLES(LC), .STAGE_CYCLES(SC), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .out_ready(out_ready),
    .state(state), .stage(stage), .cyc_cnt(cyc_cnt), .busy(busy), .done(done));

  fft_stage_ctrl #(.NUM_STAGES(NS), .LOAD_CYCLES(LC), .STAGE_CYCLES(60), .DRAIN_CYCLES(DC)) dut6 (
    .clk(clk), .rst(rst6), .start(start6), .in_valid(iv6), .out_ready(or6),
    .state(state6), .stage(stage6), .cyc_cnt(cnt6), .busy(busy6), .done(done6));

  int n_chk = 0, n_fail = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transform is a list of phases, each with a length and
  // an optional gating input; the head phase is what the outputs show.
  typedef struct {int code; int stg; int len; int gate;} ph_t;
  ph_t mq[$];
  int  mcnt = 0, mstage = 0;

  task automatic model_adv(input bit st, input bit iv, input bit ordy, input bit r);
    ph_t p;
    if (r) begin
      mq.delete(); mcnt = 0; mstage = 0;
    end else if (mq.size() == 0) begin
      if (st) begin
        mq.push_back('{1, 0, LC, 1});
        for (int s = 0; s < NS; s++) begin
          mq.push_back('{5, s, SC, 0});
          mq.push_back('{6, s, DC, 0});
          if (s < NS-1) mq.push_back('{7, s, 1, 0});
        end
        mq.push_back('{8, NS-1, LC, 2});
        mq.push_back('{9, NS-1, 1, 0});
      end
    end else begin
      p = mq[0];
      if (p.gate == 0 || (p.gate == 1 && iv) || (p.gate == 2 && ordy)) begin
        mcnt++;
        if (mcnt == p.len) begin
          mstage = p.stg;
          void'(mq.pop_front());
          mcnt = 0;
        end
      end
    end
  endtask

  task automatic step(input bit st, input bit iv, input bit ordy, input bit r, input string tag);
    int es, eg;
    start = st; in_valid = iv; out_ready = ordy; rst = r;
    model_adv(st, iv, ordy, r);
    @(posedge clk); #1;
    es = (mq.size() != 0) ? mq[0].code : 0;
    eg = (mq.size() != 0) ? mq[0].stg  : mstage;
    cmp({tag, ".state"}, int'(state), es);
    cmp({tag, ".stage"}, int'(stage), eg);
    if (es != 9) cmp({tag, ".cyc_cnt"}, int'(cyc_cnt), mcnt);
    cmp({tag, ".busy"}, int'(busy), int'(es != 0));
    cmp({tag, ".done"}, int'(done), int'(es == 9));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b1, "reset");
  endtask

  typedef struct {int cyc; int st; int stg; int bsy; int dn;} vec_t;
  vec_t tbl[10];

  task automatic run_scn(input int id, input int ncyc);
    bit st, iv, ordy, r;
    int n_done = 0, cc;
    string tag;
    tag = $sformatf("s%0d", id);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      st   = (c == 0) || (id == 4 && c == 55);
      iv   = (id == 2) ? (c % 2 == 1) : 1'b1;
      ordy = (id == 3) ? !(c >= 96 && c <= 100) : 1'b1;
      r    = (id == 5 && c == 47);
      step(st, iv, ordy, r, tag);
      cc = c + 1;
      if (done) n_done++;
      if (id == 1 || id == 4)
        for (int k = 0; k < 10; k++)
          if (tbl[k].cyc == cc) begin
            cmp($sformatf("%s.tbl%0d.state", tag, k), int'(state), tbl[k].st);
            cmp($sformatf("%s.tbl%0d.stage", tag, k), int'(stage), tbl[k].stg);
            cmp($sformatf("%s.tbl%0d.busy",  tag, k), int'(busy),  tbl[k].bsy);
            cmp($sformatf("%s.tbl%0d.done",  tag, k), int'(done),  tbl[k].dn);
          end
      if (id == 2) begin
        if (cc == 2 || cc == 3) cmp($sformatf("s2.cnt@%0d", cc), int'(cyc_cnt), 1);
        if (cc == 15) cmp("s2.load_at_15", int'(state), 1);
        if (cc == 16) cmp("s2.compute_at_16", int'(state), 5);
      end
      if (id == 3) begin
        if (cc == 100 || cc == 101) begin
          cmp($sformatf("s3.state@%0d", cc), int'(state), 8);
          cmp($sformatf("s3.cnt_frozen@%0d", cc), int'(cyc_cnt), 4);
        end
        if (cc == 104) cmp("s3.unload_at_104", int'(state), 8);
        if (cc == 105) cmp("s3.done_at_105", int'(done), 1);
        if (cc == 106) cmp("s3.idle_at_106", int'(state), 0);
      end
      if (id == 5 && cc == 48) begin
        cmp("s5.state", int'(state), 0);
        cmp("s5.stage", int'(stage), 0);
        cmp("s5.cnt",   int'(cyc_cnt), 0);
        cmp("s5.busy",  int'(busy), 0);
      end
    end
    cmp({tag, ".done_pulses"}, n_done, (id == 5) ? 0 : 1);
  endtask

  initial begin
    int n_done, cc, tcnt, pend, pend_val, nupd;
    int upd_cyc[4], upd_val[4];
    bit prev_act, act;

    tbl[0] = '{1,   1, 0, 1, 0};
    tbl[1] = '{9,   5, 0, 1, 0};
    tbl[2] = '{25,  6, 0, 1, 0};
    tbl[3] = '{29,  7, 0, 1, 0};
    tbl[4] = '{30,  5, 1, 1, 0};
    tbl[5] = '{51,  5, 2, 1, 0};
    tbl[6] = '{72,  5, 3, 1, 0};
    tbl[7] = '{92,  8, 3, 1, 0};
    tbl[8] = '{100, 9, 3, 1, 1};
    tbl[9] = '{101, 0, 3, 0, 0};

    run_scn(1, 105);
    run_scn(2, 115);
    run_scn(3, 110);
    run_scn(4, 105);
    run_scn(5, 150);

    // Random traffic, including occasional mid-transform resets.
    do_reset();
    n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(5) == 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
           $urandom_range(699) == 0, "rand");
      if (done) n_done++;
    end
    cmp("rand.enough_transforms", int'(n_done >= 5), 1);

    // Stage-delay tap: restarts on entry to codes 5/6, latches stage after 55 cycles.
    rst = 1'b1;
    rst6 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst6 = 1'b0; iv6 = 1'b1; or6 = 1'b1;
    tcnt = 0; pend = 0; pend_val = 0; nupd = 0; prev_act = 1'b0;
    for (int c = 0; c < 300; c++) begin
      start6 = (c == 0);
      @(posedge clk); #1;
      cc = c + 1;
      if (pend != 0) begin
        if (nupd < 4) begin upd_cyc[nupd] = cc; upd_val[nupd] = pend_val; end
        nupd++;
        pend = 0;
      end
      act = (state6 == 4'd5) || (state6 == 4'd6);
      if (act) begin
        tcnt = prev_act ? tcnt + 1 : 0;
        if (tcnt == 55) begin pend = 1; pend_val = int'(stage6); end
      end
      prev_act = act;
    end
    cmp("s6.tap_updates", nupd, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < nupd) begin
        cmp($sformatf("s6.tap%0d.value", k), upd_val[k], k);
        cmp($sformatf("s6.tap%0d.cycle", k), upd_cyc[k], 65 + 65*k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
